// File: rtl/gw_pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gw_pll_ctrl_pkg
// Brief   : Shared types and constants for the GW2A rPLL dynamic controller.
// Revision: 1.0
// ============================================================================
package gw_pll_ctrl_pkg;

    localparam int DSEL_W     = 6;
    localparam int LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        ERROR     = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gw_sync2.sv
`default_nettype none
// ============================================================================
// Module  : gw_sync2
// Brief   : Two-flop synchroniser for a single asynchronous level.
// Revision: 1.0
// ============================================================================
module gw_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/gw_pll_dyn_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gw_pll_dyn_ctrl
// Brief   : rPLL divider reconfiguration, lock supervision and retry control.
// Revision: 1.0
// ============================================================================
module gw_pll_dyn_ctrl
    import gw_pll_ctrl_pkg::*;
#(
    parameter int                RST_CYCLES   = 16,
    parameter int                LOCK_STABLE  = 1024,
    parameter int                LOCK_TIMEOUT = 65536,
    parameter int                MAX_RETRY    = 3,
    parameter logic [DSEL_W-1:0] DEF_IDSEL    = 6'd0,
    parameter logic [DSEL_W-1:0] DEF_FBDSEL   = 6'd1,
    parameter logic [DSEL_W-1:0] DEF_ODSEL    = 6'd8
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DSEL_W-1:0]     cfg_idsel,
    input  logic [DSEL_W-1:0]     cfg_fbdsel,
    input  logic [DSEL_W-1:0]     cfg_odsel,
    input  logic                  pll_lock,
    output logic                  pll_reset,
    output logic [DSEL_W-1:0]     pll_idsel,
    output logic [DSEL_W-1:0]     pll_fbdsel,
    output logic [DSEL_W-1:0]     pll_odsel,
    output logic                  locked,
    output logic                  user_rst_n,
    output logic                  err,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int CNT_W   = $clog2(max3(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT)) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRY) + 1;

    localparam logic [CNT_W-1:0]   c_RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_STB_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]   c_TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] c_RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_t                  r_state,     w_state_nxt;
    logic [CNT_W-1:0]        r_cnt,       w_cnt_nxt;
    logic [RETRY_W-1:0]      r_retry,     w_retry_nxt;
    logic                    r_pll_reset, w_pll_reset_nxt;
    logic [DSEL_W-1:0]       r_idsel,     w_idsel_nxt;
    logic [DSEL_W-1:0]       r_fbdsel,    w_fbdsel_nxt;
    logic [DSEL_W-1:0]       r_odsel,     w_odsel_nxt;
    logic                    r_locked,    w_locked_nxt;
    logic                    r_user_rst_n;
    logic                    r_err,       w_err_nxt;
    logic                    r_cfg_ready, w_cfg_ready_nxt;
    logic [LOSS_CNT_W-1:0]   r_loss,      w_loss_nxt;
    logic                    w_lock_s;
    logic                    w_xfer;
    logic [RETRY_W-1:0]      w_retry_inc;

    gw_sync2 #(
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clkin),
        .rst_n (rst_n),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    assign w_xfer      = cfg_valid && r_cfg_ready;
    assign w_retry_inc = r_retry + RETRY_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_retry_nxt     = r_retry;
        w_pll_reset_nxt = r_pll_reset;
        w_idsel_nxt     = r_idsel;
        w_fbdsel_nxt    = r_fbdsel;
        w_odsel_nxt     = r_odsel;
        w_locked_nxt    = r_locked;
        w_err_nxt       = r_err;
        w_loss_nxt      = r_loss;

        case (r_state)
            PLL_RST: begin
                w_pll_reset_nxt = 1'b1;
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt     = WAIT_LOCK;
                    w_cnt_nxt       = '0;
                    w_pll_reset_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TO_LAST) begin
                    w_retry_nxt     = w_retry_inc;
                    w_cnt_nxt       = '0;
                    w_pll_reset_nxt = 1'b1;
                    if (w_retry_inc == c_RETRY_MAX) begin
                        w_state_nxt = ERROR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = PLL_RST;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_STB_LAST) begin
                    w_state_nxt  = RUN;
                    w_cnt_nxt    = '0;
                    w_locked_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt     = PLL_RST;
                    w_cnt_nxt       = '0;
                    w_retry_nxt     = '0;
                    w_pll_reset_nxt = 1'b1;
                    w_locked_nxt    = 1'b0;
                    if (r_loss != '1)
                        w_loss_nxt = r_loss + LOSS_CNT_W'(1);
                end
            end
            ERROR: begin
                w_err_nxt       = 1'b1;
                w_pll_reset_nxt = 1'b1;
                w_locked_nxt    = 1'b0;
            end
            default: begin
                w_state_nxt     = PLL_RST;
                w_cnt_nxt       = '0;
                w_pll_reset_nxt = 1'b1;
                w_locked_nxt    = 1'b0;
            end
        endcase

        // An accepted configuration overrides the state's own transition, but
        // a simultaneous lock loss has already been counted above.
        if (w_xfer) begin
            w_state_nxt     = PLL_RST;
            w_cnt_nxt       = '0;
            w_retry_nxt     = '0;
            w_pll_reset_nxt = 1'b1;
            w_idsel_nxt     = cfg_idsel;
            w_fbdsel_nxt    = cfg_fbdsel;
            w_odsel_nxt     = cfg_odsel;
            w_locked_nxt    = 1'b0;
            w_err_nxt       = 1'b0;
        end

        w_cfg_ready_nxt = (w_state_nxt == RUN) || (w_state_nxt == ERROR);
    end

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_state      <= PLL_RST;
            r_cnt        <= '0;
            r_retry      <= '0;
            r_pll_reset  <= 1'b1;
            r_idsel      <= DEF_IDSEL;
            r_fbdsel     <= DEF_FBDSEL;
            r_odsel      <= DEF_ODSEL;
            r_locked     <= 1'b0;
            r_user_rst_n <= 1'b0;
            r_err        <= 1'b0;
            r_cfg_ready  <= 1'b0;
            r_loss       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retry      <= w_retry_nxt;
            r_pll_reset  <= w_pll_reset_nxt;
            r_idsel      <= w_idsel_nxt;
            r_fbdsel     <= w_fbdsel_nxt;
            r_odsel      <= w_odsel_nxt;
            r_locked     <= w_locked_nxt;
            r_user_rst_n <= w_locked_nxt;
            r_err        <= w_err_nxt;
            r_cfg_ready  <= w_cfg_ready_nxt;
            r_loss       <= w_loss_nxt;
        end
    end

    assign cfg_ready     = r_cfg_ready;
    assign pll_reset     = r_pll_reset;
    assign pll_idsel     = r_idsel;
    assign pll_fbdsel    = r_fbdsel;
    assign pll_odsel     = r_odsel;
    assign locked        = r_locked;
    assign user_rst_n    = r_user_rst_n;
    assign err           = r_err;
    assign lock_loss_cnt = r_loss;

endmodule
`default_nettype wire
